// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Steps the digit select through the digits enabled in digit_mask. It
// captures the selector value once sel has settled and drives active-low
// anodes.
// Optional feature: define SCAN_GAP_EN to insert GAP_CYCLES all-off BLANK
// cycles after each digit. This suppresses ghosting on slow anode drivers.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] digit_mask,
  input  logic [3:0] num,
  output logic [2:0] sel,
  output logic [3:0] num_out,
  output logic [7:0] an,
  output logic       frame_done
);

  // One counter serves both SHOW and BLANK, so size it for the longer of the two.
  localparam int unsigned CntMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

`ifdef SCAN_GAP_EN
  typedef enum logic [1:0] {StIdle, StSettle, StShow, StBlank} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSettle, StShow} state_e;
`endif

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      first_sel;
  logic [2:0]      next_sel;
  logic [2:0]      idx;
  logic            found;

  // Lowest enabled digit, used when a scan starts from IDLE.
  always_comb begin
    first_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (digit_mask[i]) first_sel = 3'(i);
    end
  end

  // Nearest enabled digit after sel, searching circularly.
  // The last probe (i=8) lands back on sel, which covers the single-digit case.
  always_comb begin
    next_sel = sel;
    found    = 1'b0;
    idx      = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = sel + 3'(i);
      if (!found && digit_mask[idx]) begin
        next_sel = idx;
        found    = 1'b1;
      end
    end
  end

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel        <= 3'd0;
      num_out    <= 4'd0;
      an         <= 8'hFF;
      frame_done <= 1'b0;
      cnt_q      <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state_q != StIdle && (!en || digit_mask == 8'd0)) begin
        // Abort blanks the display; sel and num_out keep their last values.
        state_q <= StIdle;
        an      <= 8'hFF;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            an <= 8'hFF;
            if (en && digit_mask != 8'd0) begin
              state_q <= StSettle;
              sel     <= first_sel;
            end
          end
          StSettle: begin
            state_q <= StShow;
            num_out <= num;
            an      <= ~(8'b1 << sel);
            cnt_q   <= '0;
          end
          StShow: begin
            if (cnt_q == CntW'(CLK_DIV - 1)) begin
              cnt_q      <= '0;
              sel        <= next_sel;
              frame_done <= (next_sel <= sel);
              an         <= 8'hFF;
`ifdef SCAN_GAP_EN
              state_q    <= StBlank;
`else
              state_q    <= StSettle;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef SCAN_GAP_EN
          StBlank: begin
            an <= 8'hFF;
            if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
              cnt_q   <= '0;
              state_q <= StSettle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`endif
          default: begin
            state_q <= StIdle;
            an      <= 8'hFF;
          end
        endcase
      end
    end
  end

endmodule
